// File: rtl/ppu_pixel_writer.sv
// Pixel writer: drains a small pixel FIFO into a 32-row screen buffer at the NES write cadence,
// framing each line with sync pulses and padding or trimming lines to LINE_PIXELS.
module ppu_pixel_writer #(
    parameter int          LINE_PIXELS = 256,
    parameter int          FRAME_LINES = 240,
    parameter int          SYNC_CYCLES = 4,
    parameter logic [5:0]  PAD_COLOR   = 6'h0F,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       nesClock_EN,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [5:0] pix_data,
    input  logic       pix_last,
    output logic       pix_ready,
    output logic       dataWrite,
    output logic       syncroSignal,
    output logic [4:0] memAddrInRow,
    output logic [5:0] dataIn,
    output logic       err_short,
    output logic       err_long,
    output logic       busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0]    COL_LAST   = 8'(LINE_PIXELS - 1);
    localparam logic [7:0]    LINE_LAST  = 8'(FRAME_LINES - 1);
    localparam logic [7:0]    SYNC_LAST  = 8'(SYNC_CYCLES - 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, FSYNC, ACTIVE, PAD, DRAIN, LDONE, LSYNC} state_t;

    state_t          state, state_next;
    logic [7:0]      col, col_next;
    logic [7:0]      line, line_next;
    logic [7:0]      sync_cnt, sync_cnt_next;
    logic [6:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            full, empty, push, pop, flush;
    logic            write_next, sync_next, short_next, long_next;
    logic [5:0]      wdata_next;
    logic            head_last;
    logic [5:0]      head_data;

    assign full         = (count == FULL_COUNT);
    assign empty        = (count == '0);
    assign pix_ready    = !full;
    assign busy         = (state != IDLE);
    assign memAddrInRow = line[4:0];
    assign {head_last, head_data} = fifo_mem[rd_ptr];
    // Pixels offered while idle, or in the same cycle as a frame restart, are dropped.
    assign push = pix_valid && !full && (state != IDLE) && !frame_start;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pix_last, pix_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_next    = state;
        col_next      = col;
        line_next     = line;
        sync_cnt_next = sync_cnt;
        write_next    = 1'b0;
        sync_next     = 1'b0;
        wdata_next    = PAD_COLOR;
        pop           = 1'b0;
        flush         = 1'b0;
        short_next    = 1'b0;
        long_next     = 1'b0;
        // A frame restart wins over everything, including the one-cycle LDONE bookkeeping.
        if (frame_start) begin
            flush         = 1'b1;
            col_next      = '0;
            line_next     = '0;
            sync_cnt_next = '0;
            state_next    = FSYNC;
        end else begin
            case (state)
                IDLE: begin
                end
                FSYNC: begin
                    if (nesClock_EN) begin
                        sync_next = 1'b1;
                        if (sync_cnt == SYNC_LAST) begin
                            sync_cnt_next = '0;
                            state_next    = ACTIVE;
                        end else begin
                            sync_cnt_next = sync_cnt + 8'd1;
                        end
                    end
                end
                ACTIVE: begin
                    if (nesClock_EN && !empty) begin
                        pop        = 1'b1;
                        write_next = 1'b1;
                        wdata_next = head_data;
                        if (col == COL_LAST) begin
                            state_next = head_last ? LDONE : DRAIN;
                            long_next  = !head_last;
                        end else begin
                            col_next = col + 8'd1;
                            if (head_last) begin
                                state_next = PAD;
                                short_next = 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    if (nesClock_EN) begin
                        write_next = 1'b1;
                        if (col == COL_LAST) begin
                            state_next = LDONE;
                        end else begin
                            col_next = col + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (nesClock_EN && !empty) begin
                        pop = 1'b1;
                        if (head_last) begin
                            state_next = LDONE;
                        end
                    end
                end
                LDONE: begin
                    col_next = '0;
                    if (line == LINE_LAST) begin
                        state_next = IDLE;
                        flush      = 1'b1;
                    end else begin
                        line_next  = line + 8'd1;
                        state_next = LSYNC;
                    end
                end
                LSYNC: begin
                    if (nesClock_EN) begin
                        sync_next  = 1'b1;
                        state_next = ACTIVE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            col          <= '0;
            line         <= '0;
            sync_cnt     <= '0;
            dataWrite    <= 1'b0;
            syncroSignal <= 1'b0;
            dataIn       <= '0;
            err_short    <= 1'b0;
            err_long     <= 1'b0;
        end else begin
            state        <= state_next;
            col          <= col_next;
            line         <= line_next;
            sync_cnt     <= sync_cnt_next;
            dataWrite    <= write_next;
            syncroSignal <= sync_next;
            if (write_next) begin
                dataIn <= wdata_next;
            end
            if (short_next) begin
                err_short <= 1'b1;
            end
            if (long_next) begin
                err_long <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ppu_pixel_writer.sv
// Bench for ppu_pixel_writer: random pixel lines are turned into the expected buffer writes and
// sync pulses line by line, then compared with what the writer actually produced.
module tb_ppu_pixel_writer;

    localparam int          LP   = 256;
    localparam int          FL   = 36;
    localparam int          SC   = 4;
    localparam int          FD   = 4;
    localparam logic [5:0]  PADC = 6'h0F;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       nesClock_EN = 1'b0;
    logic       frame_start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [5:0] pix_data = '0;
    logic       pix_last = 1'b0;
    logic       pix_ready, dataWrite, syncroSignal, err_short, err_long, busy;
    logic [4:0] memAddrInRow;
    logic [5:0] dataIn;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0]  src_q[$];
    logic [10:0] wr_q[$];
    logic [10:0] exp_wr[$];
    logic [20:0] sync_q[$];
    logic [20:0] exp_sync[$];

    bit   feed_en = 1'b0;
    int   valid_pct = 100;
    int   sent = 0;
    logic ready_cap = 1'b1;
    int   en_mode = 1;
    int   phase = 0;
    int   target, wr_mark, sync_mark, sent_mark, c;

    always #5 clk = ~clk;

    ppu_pixel_writer #(
        .LINE_PIXELS(LP),
        .FRAME_LINES(FL),
        .SYNC_CYCLES(SC),
        .PAD_COLOR(PADC),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .nesClock_EN(nesClock_EN),
        .frame_start(frame_start),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_last(pix_last),
        .pix_ready(pix_ready),
        .dataWrite(dataWrite),
        .syncroSignal(syncroSignal),
        .memAddrInRow(memAddrInRow),
        .dataIn(dataIn),
        .err_short(err_short),
        .err_long(err_long),
        .busy(busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor and cadence generator share one process so the enable seen here is the one
    // that was in force when the just-visible strobes were committed.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dataWrite) begin
                    checkOutput("write_with_en", 32'(nesClock_EN), 32'd1);
                    checkOutput("write_sync_excl", 32'(syncroSignal), 32'd0);
                    wr_q.push_back({memAddrInRow, dataIn});
                end
                if (syncroSignal) begin
                    sync_q.push_back({memAddrInRow, 16'(wr_q.size())});
                end
            end
            case (en_mode)
                0: nesClock_EN = 1'b0;
                1: nesClock_EN = 1'b1;
                default: begin
                    nesClock_EN = (phase == 0);
                    phase = (phase + 1) % 3;
                end
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (pix_valid && ready_cap && src_q.size() > 0) begin
                void'(src_q.pop_front());
                sent++;
            end
            if (feed_en && src_q.size() > 0 && int'($urandom_range(0, 99)) < valid_pct) begin
                pix_valid = 1'b1;
                {pix_last, pix_data} = src_q[0];
            end else begin
                pix_valid = 1'b0;
            end
            ready_cap = pix_ready;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus();
        feed_en = 1'b0;
        pix_valid = 1'b0;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    // One source line of n pixels becomes exactly LP buffer writes: the first LP pixels, then padding.
    task automatic add_line(input int n, input int idx, input bit ramp);
        logic [4:0] row;
        logic [5:0] d;
        row = 5'(idx % 32);
        for (int i = 0; i < n; i++) begin
            d = ramp ? 6'(i) : 6'($urandom);
            src_q.push_back({(i == n - 1), d});
            if (i < LP) exp_wr.push_back({row, d});
        end
        for (int i = n; i < LP; i++) exp_wr.push_back({row, PADC});
        if (idx == 0) begin
            repeat (SC) exp_sync.push_back({5'd0, 16'd0});
        end else begin
            exp_sync.push_back({row, 16'(idx * LP)});
        end
    endtask

    task automatic wait_writes(input int n, input int bound, input string tag);
        int k;
        k = 0;
        while (wr_q.size() < n && k < bound) begin
            tick(1);
            k++;
        end
        checkOutput(tag, 32'(wr_q.size() >= n), 32'd1);
    endtask

    task automatic compare_writes(input int n, input string tag);
        logic [10:0] got;
        for (int i = 0; i < n; i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 11'bx;
            checkOutput($sformatf("%s_write%0d", tag, i), 32'(got), 32'(exp_wr[i]));
            if (got !== exp_wr[i]) break;
        end
    endtask

    task automatic compare_syncs(input int n, input string tag);
        logic [20:0] got;
        for (int i = 0; i < n; i++) begin
            got = (i < sync_q.size()) ? sync_q[i] : 21'bx;
            checkOutput($sformatf("%s_sync%0d", tag, i), 32'(got), 32'(exp_sync[i]));
            if (got !== exp_sync[i]) break;
        end
    endtask

    task automatic check_reset(input string tag);
        checkOutput({tag, "_dataWrite"}, 32'(dataWrite), 32'd0);
        checkOutput({tag, "_syncro"}, 32'(syncroSignal), 32'd0);
        checkOutput({tag, "_row"}, 32'(memAddrInRow), 32'd0);
        checkOutput({tag, "_dataIn"}, 32'(dataIn), 32'd0);
        checkOutput({tag, "_err_short"}, 32'(err_short), 32'd0);
        checkOutput({tag, "_err_long"}, 32'(err_long), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_ready"}, 32'(pix_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        en_mode = 1;
        tick(3);
        check_reset("reset");
        rst_n = 1'b1;
        tick(2);

        // Frame A: short line 0, long line 1, then ramp lines through the end of the frame.
        src_q.delete(); exp_wr.delete(); exp_sync.delete(); wr_q.delete(); sync_q.delete();
        add_line(100, 0, 1'b0);
        add_line(300, 1, 1'b0);
        for (int l = 2; l < FL; l++) add_line(LP, l, 1'b1);
        applyStimulus();
        valid_pct = 80;
        feed_en = 1'b1;
        checkOutput("A_busy_after_start", 32'(busy), 32'd1);
        wait_writes(200, 2000, "A_line0_progress");
        checkOutput("A_err_short_line0", 32'(err_short), 32'd1);
        checkOutput("A_err_long_line0", 32'(err_long), 32'd0);
        c = 0;
        while (busy && c < 40000) begin
            tick(1);
            c++;
        end
        checkOutput("A_idle_at_end", 32'(busy), 32'd0);
        checkOutput("A_write_count", 32'(wr_q.size()), 32'(exp_wr.size()));
        compare_writes(exp_wr.size(), "A");
        checkOutput("A_sync_count", 32'(sync_q.size()), 32'(exp_sync.size()));
        compare_syncs(exp_sync.size(), "A");
        checkOutput("A_err_short_end", 32'(err_short), 32'd1);
        checkOutput("A_err_long_end", 32'(err_long), 32'd1);
        checkOutput("A_ready_idle", 32'(pix_ready), 32'd1);

        rst_n = 1'b0;
        tick(2);
        checkOutput("reset_clears_err_short", 32'(err_short), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Frame B: FIFO fill with the cadence halted, then 1-in-3 cadence and an abort at line 5 col 77.
        src_q.delete(); exp_wr.delete(); exp_sync.delete(); wr_q.delete(); sync_q.delete();
        en_mode = 0;
        tick(2);
        for (int l = 0; l < 6; l++) add_line(LP, l, 1'b0);
        applyStimulus();
        sent_mark = sent;
        valid_pct = 100;
        feed_en = 1'b1;
        c = 0;
        while (pix_ready && c < 20) begin
            tick(1);
            c++;
        end
        checkOutput("B_ready_when_full", 32'(pix_ready), 32'd0);
        checkOutput("B_accepted_when_full", 32'(sent - sent_mark), 32'(FD));
        tick(3);
        checkOutput("B_ready_stays_low", 32'(pix_ready), 32'd0);
        checkOutput("B_no_extra_accept", 32'(sent - sent_mark), 32'(FD));
        checkOutput("B_no_sync_without_en", 32'(sync_q.size()), 32'd0);
        en_mode = 3;
        valid_pct = 50;
        target = 5 * LP + 77;
        wait_writes(target, 20000, "B_reach_abort_point");
        applyStimulus();
        src_q.delete();
        tick(15);
        checkOutput("B_no_write_after_abort", 32'(wr_q.size()), 32'(target));
        compare_writes(target, "B");
        sync_mark = SC + 5;
        compare_syncs(sync_mark, "B");
        checkOutput("B_abort_sync_len", 32'(sync_q.size()), 32'(sync_mark + SC));
        for (int i = 0; i < SC; i++) begin
            checkOutput($sformatf("B_abort_sync%0d", i),
                        32'((sync_mark + i < sync_q.size()) ? sync_q[sync_mark + i] : 21'bx),
                        32'({5'd0, 16'(target)}));
        end
        checkOutput("B_abort_row", 32'(memAddrInRow), 32'd0);
        checkOutput("B_abort_err_short", 32'(err_short), 32'd0);
        checkOutput("B_abort_err_long", 32'(err_long), 32'd0);
        checkOutput("B_abort_busy", 32'(busy), 32'd1);

        // Frame C follows the abort directly; its first write must be its own first pixel.
        exp_wr.delete(); exp_sync.delete();
        add_line(LP, 0, 1'b0);
        feed_en = 1'b1;
        wait_writes(target + 1, 2000, "C_first_write_arrives");
        checkOutput("C_first_pixel", 32'((wr_q.size() > target) ? wr_q[target] : 11'bx), 32'(exp_wr[0]));
        checkOutput("C_sync_before_first", 32'(sync_q.size()), 32'(sync_mark + SC));

        // Mid-line reset, then pixels offered while idle must be swallowed without effect.
        wait_writes(target + 40, 2000, "C_midline");
        feed_en = 1'b0;
        pix_valid = 1'b0;
        src_q.delete();
        rst_n = 1'b0;
        #1;
        check_reset("midline_reset");
        en_mode = 1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        wr_mark = wr_q.size();
        sync_mark = sync_q.size();
        sent_mark = sent;
        for (int i = 0; i < 8; i++) src_q.push_back(7'($urandom));
        valid_pct = 100;
        feed_en = 1'b1;
        tick(15);
        checkOutput("idle_accepts_all", 32'(sent - sent_mark), 32'd8);
        checkOutput("idle_ready", 32'(pix_ready), 32'd1);
        checkOutput("idle_no_write", 32'(wr_q.size()), 32'(wr_mark));
        checkOutput("idle_no_sync", 32'(sync_q.size()), 32'(sync_mark));
        checkOutput("idle_busy", 32'(busy), 32'd0);

        src_q.delete(); exp_wr.delete(); exp_sync.delete();
        add_line(LP, 0, 1'b0);
        applyStimulus();
        feed_en = 1'b1;
        wait_writes(wr_mark + 1, 200, "D_first_write_arrives");
        checkOutput("D_first_pixel", 32'((wr_q.size() > wr_mark) ? wr_q[wr_mark] : 11'bx), 32'(exp_wr[0]));
        checkOutput("D_sync_count", 32'(sync_q.size() - sync_mark), 32'(SC));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
